// File: rtl/cache_pkg.sv
// Shared cache parameters, FSM state encoding and address field helpers.
// Used by dcache_controller and cache_miss_controller.
package cache_pkg;

    localparam int unsigned ADDR_BITS      = 32;
    localparam int unsigned WORD_SIZE      = 32;
    localparam int unsigned INDEX_BITS     = 5;
    localparam int unsigned BLOCK_OFFSET   = 6;
    localparam int unsigned TAG_BITS       = ADDR_BITS - INDEX_BITS - BLOCK_OFFSET;
    localparam int unsigned WORD_BITS      = BLOCK_OFFSET - 2;
    localparam int unsigned DATA_BITS      = (2 ** BLOCK_OFFSET) * 8;
    localparam int unsigned LINE_LENGTH    = TAG_BITS + DATA_BITS + 1;
    localparam int unsigned NUM_LINES      = 2 ** INDEX_BITS;
    localparam int unsigned DOFF_BITS      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_WR_THRU,
        ST_RESP
    } cache_state_t;

    typedef struct packed {
        logic [TAG_BITS-1:0]   tag;
        logic [INDEX_BITS-1:0] index;
        logic [WORD_BITS-1:0]  word;
        logic [1:0]            byte_off;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_BITS-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

    // Bit position of a word inside the line data field.
    function automatic logic [DOFF_BITS-1:0] word_bit_offset(input logic [WORD_BITS-1:0] word);
        return DOFF_BITS'(word) * DOFF_BITS'(WORD_SIZE);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/data storage with synchronous read and a single write port,
// plus the per-line valid flop vector with clear-all.
module cache_line_array
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_all,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_BITS-1:0]  rd_data,
    output logic [NUM_LINES-1:0]  valid,
    input  logic                  line_we,
    input  logic                  word_we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_BITS-1:0]  wr_line,
    input  logic [WORD_SIZE-1:0]  wr_wdata
);

    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [DATA_BITS-1:0] data_mem [NUM_LINES];

    // Line fill and word update never coincide, so one port serves both.
    always_ff @(posedge clk) begin
        rd_tag  <= tag_mem[rd_index];
        rd_data <= data_mem[rd_index];
        if (line_we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end else if (word_we) begin
            data_mem[wr_index][word_bit_offset(wr_word) +: WORD_SIZE] <= wr_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_all) begin
            valid <= '0;
        end else if (line_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_controller
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_BITS-1:0]   cpu_addr,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    input  logic                   cpu_re,
    input  logic                   cpu_wr,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic [ADDR_BITS-1:0]   miss_addr,
    output logic [WORD_SIZE-1:0]   miss_wdata,
    output logic                   miss_re,
    output logic                   miss_wr,
    output logic                   miss_enable,
    input  logic [LINE_LENGTH-1:0] miss_line,
    input  logic                   miss_full_line_wr,
    input  logic                   miss_re_ack,
    input  logic                   miss_wr_ack,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);

    cache_state_t          state;
    addr_fields_t          addr_q;
    addr_fields_t          cpu_f;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic                  wr_q;

    logic [INDEX_BITS-1:0] rd_index;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_BITS-1:0]  rd_data;
    logic [NUM_LINES-1:0]  valid;
    logic [DATA_BITS-1:0]  fill_data;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [WORD_SIZE-1:0]  cached_word;
    logic [WORD_SIZE-1:0]  fill_word;
    logic                  hit;
    logic                  fill_done;
    logic                  word_we;
    logic                  unused_line_valid;

    assign cpu_f             = split_addr(cpu_addr);
    assign fill_data         = miss_line[1 +: DATA_BITS];
    assign fill_tag          = miss_line[LINE_LENGTH-1 -: TAG_BITS];
    assign unused_line_valid = miss_line[0];

    // Present the incoming index in IDLE so the line is readable in LOOKUP.
    assign rd_index    = (state == ST_IDLE) ? cpu_f.index : addr_q.index;
    assign hit         = valid[addr_q.index] && (rd_tag == addr_q.tag);
    assign cached_word = rd_data[word_bit_offset(addr_q.word) +: WORD_SIZE];
    assign fill_word   = fill_data[word_bit_offset(addr_q.word) +: WORD_SIZE];
    assign fill_done   = (state == ST_FILL) && miss_re_ack && miss_full_line_wr;
    assign word_we     = (state == ST_LOOKUP) && wr_q && hit;

    cache_line_array u_lines (
        .clk      (clk),
        .clr_all  (!rst),
        .rd_index (rd_index),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .valid    (valid),
        .line_we  (fill_done),
        .word_we  (word_we),
        .wr_index (addr_q.index),
        .wr_word  (addr_q.word),
        .wr_tag   (fill_tag),
        .wr_line  (fill_data),
        .wr_wdata (wdata_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            cpu_rdata   <= '0;
            cpu_busy    <= 1'b0;
            cpu_done    <= 1'b0;
            miss_addr   <= '0;
            miss_wdata  <= '0;
            miss_re     <= 1'b0;
            miss_wr     <= 1'b0;
            miss_enable <= 1'b0;
        end else begin
            miss_enable <= 1'b1;
            cpu_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_re || cpu_wr) begin
                        addr_q   <= cpu_f;
                        wdata_q  <= cpu_wdata;
                        wr_q     <= cpu_wr;
                        cpu_busy <= 1'b1;
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (wr_q) begin
                        miss_wr    <= 1'b1;
                        miss_addr  <= addr_q;
                        miss_wdata <= wdata_q;
                        state      <= ST_WR_THRU;
                    end else if (hit) begin
                        cpu_rdata <= cached_word;
                        cpu_done  <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        miss_re   <= 1'b1;
                        miss_addr <= addr_q;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_done) begin
                        miss_re   <= 1'b0;
                        cpu_rdata <= fill_word;
                        cpu_done  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WR_THRU: begin
                    if (miss_wr_ack) begin
                        miss_wr   <= 1'b0;
                        cpu_rdata <= '0;
                        cpu_done  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cpu_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating lookup counters; writes count as well as reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a small miss-controller responder.
module tb_dcache_controller;
    import cache_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            cpu_addr;
    logic [31:0]            cpu_wdata;
    logic                   cpu_re;
    logic                   cpu_wr;
    logic [31:0]            cpu_rdata;
    logic                   cpu_busy;
    logic                   cpu_done;
    logic [31:0]            miss_addr;
    logic [31:0]            miss_wdata;
    logic                   miss_re;
    logic                   miss_wr;
    logic                   miss_enable;
    logic [LINE_LENGTH-1:0] miss_line;
    logic                   miss_full_line_wr;
    logic                   miss_re_ack;
    logic                   miss_wr_ack;
    logic [31:0]            hit_count;
    logic [31:0]            miss_count;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_re            (cpu_re),
        .cpu_wr            (cpu_wr),
        .cpu_rdata         (cpu_rdata),
        .cpu_busy          (cpu_busy),
        .cpu_done          (cpu_done),
        .miss_addr         (miss_addr),
        .miss_wdata        (miss_wdata),
        .miss_re           (miss_re),
        .miss_wr           (miss_wr),
        .miss_enable       (miss_enable),
        .miss_line         (miss_line),
        .miss_full_line_wr (miss_full_line_wr),
        .miss_re_ack       (miss_re_ack),
        .miss_wr_ack       (miss_wr_ack),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fills    = 0;
    int          wrs      = 0;
    int          sb_hit   = 0;
    int          sb_miss  = 0;
    logic        model_hold = 1'b0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    typedef struct {
        logic        re;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic [31:0] rdata;
    } vec_t;

    // Memory image: word i of the line at A is {A[25:6], 12'h000} + i.
    function automatic logic [LINE_LENGTH-1:0] make_line(input logic [31:0] a);
        logic [LINE_LENGTH-1:0] l;
        logic [31:0]            base;
        l    = '0;
        base = {a[25:6], 12'h000};
        for (int i = 0; i < 16; i++) l[1 + 32*i +: 32] = base + 32'(i);
        l[LINE_LENGTH-1 -: 21] = a[31:11];
        l[0] = 1'b1;
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Miss-controller responder: fill ack 4 cycles after miss_re, write ack 3 after miss_wr.
    initial begin
        int re_wait;
        int wr_wait;
        re_wait = 0;
        wr_wait = 0;
        miss_re_ack       = 1'b0;
        miss_wr_ack       = 1'b0;
        miss_full_line_wr = 1'b0;
        miss_line         = '0;
        forever begin
            @(negedge clk);
            if (miss_re_ack) begin
                miss_re_ack       = 1'b0;
                miss_full_line_wr = 1'b0;
            end else if (miss_re && !model_hold) begin
                if (re_wait == 3) begin
                    miss_line         = make_line(miss_addr);
                    miss_re_ack       = 1'b1;
                    miss_full_line_wr = 1'b1;
                    fills++;
                    re_wait = 0;
                end else begin
                    re_wait++;
                end
            end else begin
                re_wait = 0;
            end
            if (miss_wr_ack) begin
                miss_wr_ack = 1'b0;
            end else if (miss_wr) begin
                if (wr_wait == 2) begin
                    miss_wr_ack  = 1'b1;
                    last_wr_addr = miss_addr;
                    last_wr_data = miss_wdata;
                    wrs++;
                    wr_wait = 0;
                end else begin
                    wr_wait++;
                end
            end else begin
                wr_wait = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " miss_re"},     32'(miss_re), 32'd0);
        check({tag, " miss_wr"},     32'(miss_wr), 32'd0);
        check({tag, " cpu_busy"},    32'(cpu_busy), 32'd0);
        check({tag, " cpu_done"},    32'(cpu_done), 32'd0);
        check({tag, " cpu_rdata"},   cpu_rdata, 32'd0);
        check({tag, " miss_addr"},   miss_addr, 32'd0);
        check({tag, " miss_wdata"},  miss_wdata, 32'd0);
        check({tag, " miss_enable"}, 32'(miss_enable), 32'd0);
        check({tag, " hit_count"},   hit_count, 32'd0);
        check({tag, " miss_count"},  miss_count, 32'd0);
    endtask

    // Issue one request; lat counts cycles after the accepting edge.
    task automatic do_req(input logic re, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int mre, output int mwr,
                          output logic [31:0] maddr);
        @(negedge clk);
        cpu_re = re; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_re = 1'b0; cpu_wr = 1'b0;
        lat = -1; mre = -1; mwr = -1; rd = 'x; maddr = 'x;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            if (c == 1) check("busy_after_accept", 32'(cpu_busy), 32'd1);
            if (miss_re && mre < 0) begin mre = c; maddr = miss_addr; end
            if (miss_wr && mwr < 0) begin mwr = c; maddr = miss_addr; end
            if (cpu_done) begin
                lat = c;
                rd  = cpu_rdata;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(cpu_done), 32'd0);
        check("busy_released",  32'(cpu_busy), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v);
        logic [31:0] rd;
        logic [31:0] maddr;
        int lat, mre, mwr, f0, w0;
        f0 = fills;
        w0 = wrs;
        do_req(v.re, v.wr, v.addr, v.wdata, rd, lat, mre, mwr, maddr);
        check($sformatf("rdata@%h", v.addr), rd, v.rdata);
        if (v.wr) begin
            check($sformatf("wr_latency@%h", v.addr), 32'(lat), 32'd5);
            check($sformatf("miss_wr_rise@%h", v.addr), 32'(mwr), 32'd2);
            check($sformatf("wr_addr@%h", v.addr), maddr, v.addr);
            check($sformatf("wr_count@%h", v.addr), 32'(wrs - w0), 32'd1);
            check($sformatf("wr_data@%h", v.addr), last_wr_data, v.wdata);
            check($sformatf("wr_nofill@%h", v.addr), 32'(fills - f0), 32'd0);
        end else if (v.hit) begin
            check($sformatf("hit_latency@%h", v.addr), 32'(lat), 32'd2);
            check($sformatf("hit_no_miss_re@%h", v.addr), 32'(mre), 32'hFFFF_FFFF);
            check($sformatf("hit_nofill@%h", v.addr), 32'(fills - f0), 32'd0);
        end else begin
            check($sformatf("miss_latency@%h", v.addr), 32'(lat), 32'd6);
            check($sformatf("miss_re_rise@%h", v.addr), 32'(mre), 32'd2);
            check($sformatf("fill_addr@%h", v.addr), maddr, v.addr);
            check($sformatf("fill_count@%h", v.addr), 32'(fills - f0), 32'd1);
        end
        if (v.hit) sb_hit++; else sb_miss++;
    endtask

    task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, " hit_count"},  hit_count,  32'(sb_hit));
        check({tag, " miss_count"}, miss_count, 32'(sb_miss));
`else
        check({tag, " hit_count"},  hit_count,  32'd0);
        check({tag, " miss_count"}, miss_count, 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[13];
        vec_t post[2];
        int   waited;

        //          re    wr    addr           wdata          hit   rdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h0000_1000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         1'b1, 32'h0000_1002};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         1'b0, 32'h0008_0000};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0840, 32'h0,         1'b0, 32'h0002_1000};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h0000_1000};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_007C, 32'hCAFE_F00D, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0078, 32'h0,         1'b1, 32'h0000_100E};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b0, 32'hFFFF_F00F};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         1'b1, 32'hFFFF_F00E};
        post[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'h0000_1000};
        post[1]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'h0000_1001};

        cpu_re = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check("miss_enable_after_reset", 32'(miss_enable), 32'd1);

        foreach (vecs[i]) apply_vec(vecs[i]);
        check_stats("stats");

        // Reset while a fill is outstanding.
        model_hold = 1'b1;
        @(negedge clk);
        cpu_re = 1'b1; cpu_addr = 32'h0000_1040;
        @(negedge clk);
        cpu_re = 1'b0;
        waited = 0;
        while (!miss_re && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("fill_started", 32'(miss_re), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_fill_reset");
        repeat (2) begin
            @(negedge clk);
            check("no_done_in_reset", 32'(cpu_done), 32'd0);
        end
        rst = 1'b1;
        model_hold = 1'b0;
        sb_hit  = 0;
        sb_miss = 0;
        @(negedge clk);
        check("no_done_after_reset", 32'(cpu_done), 32'd0);
        check("idle_after_reset", 32'(cpu_busy), 32'd0);

        foreach (post[i]) apply_vec(post[i]);
        check_stats("stats_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store port and `cache_miss_controller`. It owns tag/data/valid storage, performs hit/miss lookup, and issues line-fill reads and single-word write-throughs to the miss controller. It accepts returned full lines and answers the CPU with a one-cycle done pulse.

## Interface
- `WORD_SIZE`, 32: CPU and bus word width in bits.
- `INDEX_BITS`, 5: number of index bits; the cache has 2**INDEX_BITS lines.
- `BLOCK_OFFSET`, 6: byte-offset bits; a line is 64 bytes, or 16 words.
- `TAG_BITS`, 32-INDEX_BITS-BLOCK_OFFSET: tag width.
- `LINE_LENGTH`, TAG_BITS+2**BLOCK_OFFSET*8+1: width of a miss-controller line.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cpu_addr` in 32: byte address; bits [1:0] are ignored.
- `cpu_wdata` in WORD_SIZE: store data.
- `cpu_re`, `cpu_wr` in 1: request strobes, sampled only while `cpu_busy`=0.
- `cpu_rdata` out WORD_SIZE: load data, valid when `cpu_done`=1.
- `cpu_busy` out 1: request in flight.
- `cpu_done` out 1: one-cycle completion pulse.
- `miss_addr` out 32: address to the miss controller.
- `miss_wdata` out WORD_SIZE: write-through data.
- `miss_re`, `miss_wr` out 1: fill and write-through requests.
- `miss_enable` out 1: miss-controller enable.
- `miss_line` in LINE_LENGTH: returned line, laid out as {tag, data, valid}.
- `miss_full_line_wr` in 1: `miss_line` is valid.
- `miss_re_ack`, `miss_wr_ack` in 1: miss-controller completion.
- `hit_count`, `miss_count` out 32: statistics (see Configuration).

## Operation
- Line layout:
  - bit 0 is valid;
  - bits [DATA+0:1] hold data, with word i at data[32i+31:32i];
  - the tag occupies the MSBs.
- Storage:
  - tag/data arrays have synchronous read and one write port;
  - valid bits are a flop vector.
- Address fields: tag=addr[31:INDEX_BITS+BLOCK_OFFSET], index=next INDEX_BITS, word=addr[BLOCK_OFFSET-1:2].
- States: IDLE, LOOKUP, FILL, WR_THRU, RESP.
- IDLE: on `cpu_re|cpu_wr`, register addr, wdata and op, then go to LOOKUP. `cpu_wr` wins if both are high.
- LOOKUP: hit = valid[index] & (tag match).
  - Read hit: go to RESP with the cached word.
  - Read miss: go to FILL.
  - Write, hit or miss: go to WR_THRU. On a hit, overwrite the cached word in this cycle. A write miss does not allocate.
- FILL:
  - Hold `miss_re`=1 with `miss_addr`=registered addr.
  - On `miss_re_ack & miss_full_line_wr`: write the tag and data from `miss_line`, set valid[index], select the requested word from `miss_line`, drop `miss_re`, and go to RESP.
- WR_THRU:
  - Hold `miss_wr`=1 with `miss_addr` and `miss_wdata` registered.
  - On `miss_wr_ack`: drop `miss_wr` and go to RESP.
- RESP: `cpu_done`=1 for one cycle, then go to IDLE. `cpu_rdata` is held until the next done pulse; for writes it is 0.
- `miss_enable`=0 during reset and 1 otherwise.
- Acks arriving in a state that does not expect them are ignored.

## Timing
- Request in IDLE at cycle N:
  - `cpu_busy`=1 from N+1 to the RESP cycle inclusive;
  - a read hit gives `cpu_done` at N+2.
- Read miss: `miss_re` rises at N+2; `cpu_done` comes one cycle after the ack cycle.
- Write: `miss_wr` rises at N+2; `cpu_done` comes one cycle after `miss_wr_ack`.
- A new request is accepted earliest in the cycle after RESP. Back-to-back reads to a just-filled line hit.
- Reset (`rst`=0 at a clock edge), including mid-FILL or mid-WR_THRU:
  - state returns to IDLE;
  - all valid bits clear;
  - `miss_re`, `miss_wr`, `cpu_busy`, `cpu_done`, `cpu_rdata`, `miss_addr`, `miss_wdata` and `miss_enable` go to 0;
  - counters go to 0;
  - the in-flight CPU request is dropped with no `cpu_done`.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments on every LOOKUP hit and `miss_count` on every LOOKUP miss (reads and writes);
  - both counters saturate at 32'hFFFFFFFF.
- Undefined: the counter logic is absent and both ports are tied to 0.

## Structure
- Shared package `cache_pkg` holds:
  - state encodings;
  - default WORD_SIZE/INDEX_BITS/BLOCK_OFFSET;
  - TAG_BITS/LINE_LENGTH derivations;
  - address field-extract helpers (shared with `cache_miss_controller`).
- Sub-module `cache_line_array` holds the tag/data storage and valid vector, with synchronous read, one write port, word-write enable and a clear-all-valid input.

## Test plan
- Reset, then read 0x0000_0040 → miss. `miss_re`=1 at N+2 with `miss_addr`=0x40. The model returns words 0x1000+i with a full-line ack. `cpu_rdata`=0x1000 and `cpu_done`=1 for one cycle.
- Read 0x0000_0048 after that → hit. `cpu_done` at N+2, `cpu_rdata`=0x1002, `miss_re` stays 0.
- Write 0xDEADBEEF to 0x44 (hit) → `miss_wr` with addr 0x44. After the ack, a read of 0x44 hits and returns 0xDEADBEEF.
- Write to 0x2000 (miss) → write-through only. A following read of 0x2000 misses. Read 0x840, which shares index 1 with 0x40, → miss that evicts it; a reread of 0x40 then misses.
- Assert `rst`=0 mid-FILL → all outputs 0, no `cpu_done`. After release, a read of 0x40 misses.
- Both `cpu_re` and `cpu_wr` high → write path taken. With `DCACHE_STATS_EN` defined, the counters match the scoreboard hit and miss totals.
